// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipelined controller: opcodes, ALU op classes and
// the control bundles carried through the ID/EX, EX/MEM and MEM/WB registers.
package pipe_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_MUL   = 6'b011100;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       regwrite;
        logic       regdst;
        logic       alusrc;
        logic       branch;
        logic       memwrite;
        logic       memtoreg;
        logic       jump;
        logic [1:0] aluop;
        logic       mul;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // The jump is fully resolved in ID, so EX and later stages never see it.
    typedef struct packed {
        logic       regwrite;
        logic       regdst;
        logic       alusrc;
        logic       branch;
        logic       memwrite;
        logic       memtoreg;
        logic [1:0] aluop;
        logic       mul;
        logic       illegal;
    } ex_ctrl_t;

    localparam ex_ctrl_t EX_BUBBLE = '0;

    // A J leaves ID as a no-write bubble.
    function automatic ex_ctrl_t to_ex(input ctrl_t c);
        ex_ctrl_t e;
        e = EX_BUBBLE;
        if (!c.jump) begin
            e.regwrite = c.regwrite;
            e.regdst   = c.regdst;
            e.alusrc   = c.alusrc;
            e.branch   = c.branch;
            e.memwrite = c.memwrite;
            e.memtoreg = c.memtoreg;
            e.aluop    = c.aluop;
            e.mul      = c.mul;
            e.illegal  = c.illegal;
        end
        return e;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational opcode decoder producing the full control bundle.
// Shared with the single-cycle controller.
module ctrl_decode
    import pipe_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = CTRL_BUBBLE;
        case (opcode)
            OP_RTYPE: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
                ctrl.aluop    = ALUOP_FUNCT;
            end
            OP_LW: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.memtoreg = 1'b1;
                ctrl.aluop    = ALUOP_ADD;
            end
            OP_SW: begin
                ctrl.alusrc   = 1'b1;
                ctrl.memwrite = 1'b1;
                ctrl.aluop    = ALUOP_ADD;
            end
            OP_BEQ: begin
                ctrl.branch   = 1'b1;
                ctrl.aluop    = ALUOP_SUB;
            end
            OP_ADDI: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.aluop    = ALUOP_ADD;
            end
            OP_J: begin
                ctrl.jump     = 1'b1;
            end
            OP_MUL: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
                ctrl.aluop    = ALUOP_FUNCT;
                ctrl.mul      = 1'b1;
            end
            default: begin
                ctrl.illegal  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined main controller: decodes ID, owns the ID/EX, EX/MEM and MEM/WB
// control registers, and generates load-use, MUL, branch and jump hazard controls.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int MUL_LATENCY = 3,
    parameter int CNT_W       = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            id_opcode,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  ex_branch_taken,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  ifid_flush,
    output logic                  ex_alusrc,
    output logic                  ex_regdst,
    output logic                  ex_branch,
    output logic                  ex_mul,
    output logic                  ex_illegal,
    output logic [1:0]            ex_aluop,
    output logic                  mem_memwrite,
    output logic                  mem_memtoreg,
    output logic                  mem_regwrite,
    output logic                  wb_regwrite,
    output logic                  wb_memtoreg,
    output logic                  mul_busy
);

    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LATENCY - 1);

    ctrl_t                 id_ctrl;
    ex_ctrl_t              idex_p0;
    logic [REG_ADDR_W-1:0] ex_rt_p0;
    logic [CNT_W-1:0]      mul_cnt_p0;
    logic                  mem_memwrite_p1;
    logic                  mem_memtoreg_p1;
    logic                  mem_regwrite_p1;
    logic                  wb_regwrite_p2;
    logic                  wb_memtoreg_p2;

    logic branch_flush;
    logic load_use;
    logic mul_hold;
    logic lu_stall;
    logic stall;

    ctrl_decode u_decode (
        .opcode (id_opcode),
        .ctrl   (id_ctrl)
    );

    // Hazard resolution, highest priority first: branch flush, MUL, load-use, jump.
    always_comb begin
        branch_flush = ex_branch_taken & idex_p0.branch;
        load_use     = idex_p0.memtoreg & ((ex_rt_p0 == id_rs) | (ex_rt_p0 == id_rt));
        mul_hold     = idex_p0.mul & (mul_cnt_p0 < MUL_LAST) & ~branch_flush;
        lu_stall     = load_use & ~branch_flush & ~mul_hold;
        stall        = mul_hold | lu_stall;

        pc_en        = ~stall;
        ifid_en      = ~stall;
        ifid_flush   = branch_flush | (id_ctrl.jump & ~stall);
        mul_busy     = mul_hold;
    end

    // ID -> EX
    always_ff @(posedge clk) begin
        if (reset) begin
            idex_p0    <= EX_BUBBLE;
            ex_rt_p0   <= '0;
            mul_cnt_p0 <= '0;
        end else begin
            if (branch_flush || lu_stall) begin
                idex_p0 <= EX_BUBBLE;
            end else if (!mul_hold) begin
                idex_p0 <= to_ex(id_ctrl);
            end
            if (!mul_hold) begin
                ex_rt_p0 <= id_rt;
            end
            mul_cnt_p0 <= mul_hold ? mul_cnt_p0 + CNT_W'(1) : '0;
        end
    end

    // EX -> MEM
    always_ff @(posedge clk) begin
        if (reset || mul_hold) begin
            mem_memwrite_p1 <= 1'b0;
            mem_memtoreg_p1 <= 1'b0;
            mem_regwrite_p1 <= 1'b0;
        end else begin
            mem_memwrite_p1 <= idex_p0.memwrite;
            mem_memtoreg_p1 <= idex_p0.memtoreg;
            mem_regwrite_p1 <= idex_p0.regwrite;
        end
    end

    // MEM -> WB
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_regwrite_p2 <= 1'b0;
            wb_memtoreg_p2 <= 1'b0;
        end else begin
            wb_regwrite_p2 <= mem_regwrite_p1;
            wb_memtoreg_p2 <= mem_memtoreg_p1;
        end
    end

    assign ex_alusrc    = idex_p0.alusrc;
    assign ex_regdst    = idex_p0.regdst;
    assign ex_branch    = idex_p0.branch;
    assign ex_mul       = idex_p0.mul;
    assign ex_illegal   = idex_p0.illegal;
    assign ex_aluop     = idex_p0.aluop;
    assign mem_memwrite = mem_memwrite_p1;
    assign mem_memtoreg = mem_memtoreg_p1;
    assign mem_regwrite = mem_regwrite_p1;
    assign wb_regwrite  = wb_regwrite_p2;
    assign wb_memtoreg  = wb_memtoreg_p2;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: one instance at MUL_LATENCY=3 and one at
// MUL_LATENCY=1, driven with the same ID stream and checked step by step.
module tb_pipe_ctrl_unit;

    logic       clk;
    logic       reset;
    logic [5:0] id_opcode;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       ex_branch_taken;

    logic pc_en, ifid_en, ifid_flush, ex_alusrc, ex_regdst, ex_branch, ex_mul, ex_illegal;
    logic [1:0] ex_aluop;
    logic mem_memwrite, mem_memtoreg, mem_regwrite, wb_regwrite, wb_memtoreg, mul_busy;

    logic d1_pc_en, d1_ifid_en, d1_ifid_flush, d1_ex_alusrc, d1_ex_regdst, d1_ex_branch;
    logic d1_ex_mul, d1_ex_illegal;
    logic [1:0] d1_ex_aluop;
    logic d1_mem_memwrite, d1_mem_memtoreg, d1_mem_regwrite, d1_wb_regwrite, d1_wb_memtoreg;
    logic d1_mul_busy;

    int tests = 0;
    int fails = 0;

    localparam logic [5:0] RTYPE = 6'b000000;
    localparam logic [5:0] LW    = 6'b100011;
    localparam logic [5:0] SW    = 6'b101011;
    localparam logic [5:0] BEQ   = 6'b000100;
    localparam logic [5:0] ADDI  = 6'b001000;
    localparam logic [5:0] JMP   = 6'b000010;
    localparam logic [5:0] MUL   = 6'b011100;
    localparam logic [5:0] BAD   = 6'b111111;

    pipe_ctrl_unit #(.REG_ADDR_W(5), .MUL_LATENCY(3), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .ex_branch_taken(ex_branch_taken), .pc_en(pc_en), .ifid_en(ifid_en),
        .ifid_flush(ifid_flush), .ex_alusrc(ex_alusrc), .ex_regdst(ex_regdst),
        .ex_branch(ex_branch), .ex_mul(ex_mul), .ex_illegal(ex_illegal), .ex_aluop(ex_aluop),
        .mem_memwrite(mem_memwrite), .mem_memtoreg(mem_memtoreg), .mem_regwrite(mem_regwrite),
        .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .mul_busy(mul_busy)
    );

    pipe_ctrl_unit #(.REG_ADDR_W(5), .MUL_LATENCY(1), .CNT_W(4)) dut1 (
        .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .ex_branch_taken(ex_branch_taken), .pc_en(d1_pc_en), .ifid_en(d1_ifid_en),
        .ifid_flush(d1_ifid_flush), .ex_alusrc(d1_ex_alusrc), .ex_regdst(d1_ex_regdst),
        .ex_branch(d1_ex_branch), .ex_mul(d1_ex_mul), .ex_illegal(d1_ex_illegal),
        .ex_aluop(d1_ex_aluop), .mem_memwrite(d1_mem_memwrite), .mem_memtoreg(d1_mem_memtoreg),
        .mem_regwrite(d1_mem_regwrite), .wb_regwrite(d1_wb_regwrite),
        .wb_memtoreg(d1_wb_memtoreg), .mul_busy(d1_mul_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
        id_opcode = op;
        id_rs     = rs;
        id_rt     = rt;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        ex_branch_taken = 1'b0;
        set_id(ADDI, 5'd0, 5'd0);
        tick();
        tick();
        chk("rst_ex_alusrc", ex_alusrc, 0);
        chk("rst_ex_aluop", ex_aluop, 0);
        chk("rst_mem_regwrite", mem_regwrite, 0);
        chk("rst_wb_regwrite", wb_regwrite, 0);
        chk("rst_pc_en", pc_en, 1);
        chk("rst_ifid_en", ifid_en, 1);
        chk("rst_ifid_flush", ifid_flush, 0);
        chk("rst_mul_busy", mul_busy, 0);

        // ADDI walks EX -> MEM -> WB
        reset = 1'b0;
        tick();
        chk("addi_ex_alusrc", ex_alusrc, 1);
        chk("addi_mem_regwrite_early", mem_regwrite, 0);
        set_id(RTYPE, 5'd1, 5'd2);
        tick();
        chk("addi_mem_regwrite", mem_regwrite, 1);
        chk("rtype_ex_regdst", ex_regdst, 1);
        chk("rtype_ex_aluop", ex_aluop, 2);
        chk("rtype_ex_alusrc", ex_alusrc, 0);
        chk("addi_wb_early", wb_regwrite, 0);

        // taken outcome without a branch in EX is ignored
        ex_branch_taken = 1'b1;
        set_id(LW, 5'd3, 5'd8);
        chk("nobr_ifid_flush", ifid_flush, 0);
        chk("nobr_pc_en", pc_en, 1);
        ex_branch_taken = 1'b0;
        tick();
        chk("addi_wb_regwrite", wb_regwrite, 1);
        chk("lw_ex_alusrc", ex_alusrc, 1);

        // load-use: LW r8 then ADD using rs=8
        set_id(RTYPE, 5'd8, 5'd4);
        chk("lu_pc_en", pc_en, 0);
        chk("lu_ifid_en", ifid_en, 0);
        chk("lu_ifid_flush", ifid_flush, 0);
        chk("lu_mul_busy", mul_busy, 0);
        tick();
        chk("lu_bubble_regdst", ex_regdst, 0);
        chk("lu_bubble_aluop", ex_aluop, 0);
        chk("lu_bubble_alusrc", ex_alusrc, 0);
        chk("lu_mem_memtoreg", mem_memtoreg, 1);
        chk("lu_released_pc_en", pc_en, 1);
        tick();
        chk("lu_add_ex_regdst", ex_regdst, 1);
        chk("lu_add_ex_aluop", ex_aluop, 2);
        chk("lu_mem_bubble", mem_regwrite, 0);
        chk("lu_wb_memtoreg", wb_memtoreg, 1);

        // MUL, latency 3 on dut and 1 on dut1
        set_id(MUL, 5'd5, 5'd6);
        tick();
        chk("mul_c1_ex_mul", ex_mul, 1);
        chk("mul_c1_busy", mul_busy, 1);
        chk("mul_c1_pc_en", pc_en, 0);
        chk("mul_c1_ifid_en", ifid_en, 0);
        chk("mul_c1_mem_regwrite", mem_regwrite, 1);
        chk("mul1_ex_mul", d1_ex_mul, 1);
        chk("mul1_busy", d1_mul_busy, 0);
        chk("mul1_pc_en", d1_pc_en, 1);
        set_id(ADDI, 5'd0, 5'd0);
        tick();
        chk("mul_c2_ex_mul", ex_mul, 1);
        chk("mul_c2_busy", mul_busy, 1);
        chk("mul_c2_mem_bubble", mem_regwrite, 0);
        chk("mul1_next_ex_mul", d1_ex_mul, 0);
        chk("mul1_next_busy", d1_mul_busy, 0);
        chk("mul1_mem_regwrite", d1_mem_regwrite, 1);
        tick();
        chk("mul_c3_ex_mul", ex_mul, 1);
        chk("mul_c3_busy", mul_busy, 0);
        chk("mul_c3_pc_en", pc_en, 1);
        chk("mul_c3_mem_bubble", mem_regwrite, 0);
        tick();
        chk("mul_done_ex_mul", ex_mul, 0);
        chk("mul_done_ex_alusrc", ex_alusrc, 1);
        chk("mul_done_mem_regwrite", mem_regwrite, 1);
        chk("mul_done_busy", mul_busy, 0);

        // taken branch while ID reads the register BEQ names as rt
        set_id(BEQ, 5'd7, 5'd9);
        tick();
        chk("beq_ex_branch", ex_branch, 1);
        chk("beq_ex_aluop", ex_aluop, 1);
        ex_branch_taken = 1'b1;
        set_id(RTYPE, 5'd9, 5'd9);
        chk("br_ifid_flush", ifid_flush, 1);
        chk("br_pc_en", pc_en, 1);
        chk("br_ifid_en", ifid_en, 1);
        chk("br_mul_busy", mul_busy, 0);
        tick();
        ex_branch_taken = 1'b0;
        chk("br_bubble_branch", ex_branch, 0);
        chk("br_bubble_regdst", ex_regdst, 0);

        // jump in ID
        set_id(JMP, 5'd0, 5'd0);
        chk("j_ifid_flush", ifid_flush, 1);
        chk("j_pc_en", pc_en, 1);
        tick();
        chk("j_ex_bubble_alusrc", ex_alusrc, 0);
        set_id(ADDI, 5'd0, 5'd0);
        chk("j_flush_once", ifid_flush, 0);
        tick();
        chk("j_mem_regwrite", mem_regwrite, 0);
        chk("j_mem_memwrite", mem_memwrite, 0);
        tick();
        chk("j_wb_regwrite", wb_regwrite, 0);

        // jump held behind a load-use stall
        set_id(LW, 5'd0, 5'd10);
        tick();
        set_id(JMP, 5'd10, 5'd0);
        chk("jlu_pc_en", pc_en, 0);
        chk("jlu_ifid_flush", ifid_flush, 0);
        tick();
        chk("jlu_release_flush", ifid_flush, 1);
        chk("jlu_release_pc_en", pc_en, 1);
        tick();

        // illegal opcode, then SW
        set_id(BAD, 5'd0, 5'd0);
        tick();
        chk("ill_ex_illegal", ex_illegal, 1);
        chk("ill_ex_regdst", ex_regdst, 0);
        chk("ill_ex_alusrc", ex_alusrc, 0);
        chk("ill_no_x", {31'b0, $isunknown({pc_en, ifid_en, ifid_flush, ex_alusrc, ex_regdst,
            ex_branch, ex_mul, ex_illegal, ex_aluop, mem_memwrite, mem_memtoreg, mem_regwrite,
            wb_regwrite, wb_memtoreg, mul_busy})}, 0);
        set_id(SW, 5'd0, 5'd0);
        tick();
        chk("ill_clears", ex_illegal, 0);
        chk("ill_mem_regwrite", mem_regwrite, 0);
        chk("ill_mem_memwrite", mem_memwrite, 0);
        chk("sw_ex_alusrc", ex_alusrc, 1);
        set_id(ADDI, 5'd0, 5'd0);
        tick();
        chk("sw_mem_memwrite", mem_memwrite, 1);
        chk("sw_mem_regwrite", mem_regwrite, 0);

        // reset in the middle of a MUL stall
        set_id(MUL, 5'd1, 5'd2);
        tick();
        chk("rmul_busy", mul_busy, 1);
        reset = 1'b1;
        tick();
        chk("rmul_ex_mul", ex_mul, 0);
        chk("rmul_busy_clr", mul_busy, 0);
        chk("rmul_mem_regwrite", mem_regwrite, 0);
        chk("rmul_wb_regwrite", wb_regwrite, 0);
        chk("rmul_pc_en", pc_en, 1);
        reset = 1'b0;
        tick();
        chk("rmul2_c1_busy", mul_busy, 1);
        tick();
        chk("rmul2_c2_busy", mul_busy, 1);
        tick();
        chk("rmul2_c3_busy", mul_busy, 0);
        chk("rmul2_c3_ex_mul", ex_mul, 1);
        chk("d1_no_x", {31'b0, $isunknown({d1_pc_en, d1_ifid_en, d1_ifid_flush, d1_ex_alusrc,
            d1_ex_regdst, d1_ex_branch, d1_ex_mul, d1_ex_illegal, d1_ex_aluop, d1_mem_memwrite,
            d1_mem_memtoreg, d1_mem_regwrite, d1_wb_regwrite, d1_wb_memtoreg, d1_mul_busy})}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
